// File: rtl/cmp_mon_pkg.sv
// cmp_mon_pkg: shared widths, event record type and channel-index width helper for cmp_event_monitor
package cmp_mon_pkg;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int NCH_D = 4;
  localparam int W_D = 8;
  localparam int TSW_D = 16;
  localparam int CHW_D = ch_w(NCH_D);
  typedef struct packed {
    logic [CHW_D-1:0] ch;
    logic             eq;
    logic [W_D-1:0]   a;
    logic [W_D-1:0]   b;
    logic [TSW_D-1:0] ts;
  } evt_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered first-word-fall-through FIFO; push/pop/din in, dout/full/empty out
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/cmp_event_monitor.sv
// cmp_event_monitor: per-channel a/b change monitor emitting timestamped a==b events through a FIFO
// in: clk, rst, en, a_i/b_i (NCH packed W-bit channels), clr_stats, evt_ready
// out: evt_valid + evt_{ch,eq,a,b,time}, match_cnt, mismatch_cnt, overflow
module cmp_event_monitor
  import cmp_mon_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W = 8,
  parameter int DEPTH = 8,
  parameter int TSW = 16,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH*W-1:0]      a_i,
  input  logic [NCH*W-1:0]      b_i,
  input  logic                  clr_stats,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ch_w(NCH)-1:0]  evt_ch,
  output logic                  evt_eq,
  output logic [W-1:0]          evt_a,
  output logic [W-1:0]          evt_b,
  output logic [TSW-1:0]        evt_time,
  output logic [CW-1:0]         match_cnt,
  output logic [CW-1:0]         mismatch_cnt,
  output logic                  overflow
);
  localparam int CHW = ch_w(NCH);
  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           eq;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [TSW-1:0] ts;
  } rec_t;
  rec_t slot_q [NCH];
  rec_t slot_d [NCH];
  rec_t push_rec, head, evt;
  logic [NCH-1:0] pending_q, pending_d, primed_q, primed_d, change;
  logic [NCH*W-1:0] last_a_q, last_a_d, last_b_q, last_b_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [CW-1:0] match_q, match_d, mismatch_q, mismatch_d;
  logic ovf_q, ovf_d, ovf_set, push, full, empty, taken;
  logic [CHW-1:0] sel;
  always_comb begin
    sel = '0;
    for (int k = NCH - 1; k >= 0; k--) if (pending_q[k]) sel = CHW'(k);
    push = |pending_q & ~full;
    push_rec = slot_q[sel];
    ovf_set = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      change[k] = en & (~primed_q[k] | (a_i[k*W +: W] != last_a_q[k*W +: W]) | (b_i[k*W +: W] != last_b_q[k*W +: W]));
      taken = push & (sel == CHW'(k));
      // a change landing on the channel being pushed re-arms it without loss
      ovf_set = ovf_set | (change[k] & pending_q[k] & ~taken);
      pending_d[k] = (pending_q[k] & ~taken) | change[k];
      slot_d[k] = change[k] ? '{ch: CHW'(k), eq: a_i[k*W +: W] == b_i[k*W +: W], a: a_i[k*W +: W], b: b_i[k*W +: W], ts: ts_q} : slot_q[k];
    end
    taken = 1'b0;
    primed_d = primed_q | {NCH{en}};
    last_a_d = en ? a_i : last_a_q;
    last_b_d = en ? b_i : last_b_q;
    ts_d = en ? ts_q + TSW'(1) : ts_q;
    match_d = clr_stats ? '0 : (push & push_rec.eq & ~&match_q) ? match_q + CW'(1) : match_q;
    mismatch_d = clr_stats ? '0 : (push & ~push_rec.eq & ~&mismatch_q) ? mismatch_q + CW'(1) : mismatch_q;
    ovf_d = ~clr_stats & (ovf_q | ovf_set);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '{default: '0};
      pending_q <= '0;
      primed_q <= '0;
      last_a_q <= '0;
      last_b_q <= '0;
      ts_q <= '0;
      match_q <= '0;
      mismatch_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      pending_q <= pending_d;
      primed_q <= primed_d;
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
      ts_q <= ts_d;
      match_q <= match_d;
      mismatch_q <= mismatch_d;
      ovf_q <= ovf_d;
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .DW($bits(rec_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(evt_ready),
    .din(push_rec),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign evt = empty ? '0 : head;
  assign evt_valid = ~empty;
  assign evt_ch = evt.ch;
  assign evt_eq = evt.eq;
  assign evt_a = evt.a;
  assign evt_b = evt.b;
  assign evt_time = evt.ts;
  assign match_cnt = match_q;
  assign mismatch_cnt = mismatch_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_cmp_event_monitor.sv
// tb_cmp_event_monitor: directed self-checking bench for cmp_event_monitor
module tb_cmp_event_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0, clr_stats = 1'b0, evt_ready = 1'b0;
  logic [7:0] a [4] = '{default: 8'd0};
  logic [7:0] b [4] = '{default: 8'd0};
  logic [31:0] a_i, b_i;
  logic evt_valid, evt_eq, overflow;
  logic [1:0] evt_ch;
  logic [7:0] evt_a, evt_b;
  logic [15:0] evt_time, match_cnt, mismatch_cnt;
  logic rst1 = 1'b1, en1 = 1'b0;
  logic [7:0] a1 [4] = '{default: 8'd0};
  logic [31:0] a1_i;
  logic evt_valid1, evt_eq1, overflow1;
  logic [1:0] evt_ch1;
  logic [7:0] evt_a1, evt_b1;
  logic [3:0] evt_time1;
  logic [15:0] match_cnt1, mismatch_cnt1;
  int checks = 0, errors = 0, ecnt = 0, t = 0;
  typedef struct {int ch; int eq; int a; int b; int ts;} ev_t;
  ev_t q0 [$];
  ev_t q1 [$];
  assign a_i = {a[3], a[2], a[1], a[0]};
  assign b_i = {b[3], b[2], b[1], b[0]};
  assign a1_i = {a1[3], a1[2], a1[1], a1[0]};
  cmp_event_monitor u0 (
    .clk(clk), .rst(rst), .en(en), .a_i(a_i), .b_i(b_i), .clr_stats(clr_stats),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_eq(evt_eq),
    .evt_a(evt_a), .evt_b(evt_b), .evt_time(evt_time), .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt), .overflow(overflow)
  );
  cmp_event_monitor #(.TSW(4)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .a_i(a1_i), .b_i(32'd0), .clr_stats(1'b0),
    .evt_valid(evt_valid1), .evt_ready(1'b1), .evt_ch(evt_ch1), .evt_eq(evt_eq1),
    .evt_a(evt_a1), .evt_b(evt_b1), .evt_time(evt_time1), .match_cnt(match_cnt1),
    .mismatch_cnt(mismatch_cnt1), .overflow(overflow1)
  );
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) q0.push_back('{int'(evt_ch), int'(evt_eq), int'(evt_a), int'(evt_b), int'(evt_time)});
    if (!rst1 && evt_valid1) q1.push_back('{int'(evt_ch1), int'(evt_eq1), int'(evt_a1), int'(evt_b1), int'(evt_time1)});
  end
  task automatic step();
    @(posedge clk);
    ecnt = rst ? 0 : en ? ecnt + 1 : ecnt;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d exp 0", evt_valid); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL reset_match: got %0d exp 0", match_cnt); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL reset_mismatch: got %0d exp 0", mismatch_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0d exp 0", overflow); end
    rst = 1'b0;
  endtask
  task automatic test_prime();
    evt_ready = 1'b1;
    en = 1'b1;
    step();
    repeat (20) if (q0.size() < 4) step();
    checks++; if (q0.size() != 4) begin errors++; $display("FAIL prime_count: got %0d exp 4", q0.size()); end
    for (int k = 0; k < 4 && k < q0.size(); k++) begin
      checks++; if (q0[k].ch != k || q0[k].eq != 1 || q0[k].ts != 0) begin errors++; $display("FAIL prime_evt%0d: got ch=%0d eq=%0d t=%0d exp ch=%0d eq=1 t=0", k, q0[k].ch, q0[k].eq, q0[k].ts, k); end
    end
    checks++; if (match_cnt !== 16'd4) begin errors++; $display("FAIL prime_match: got %0d exp 4", match_cnt); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL prime_mismatch: got %0d exp 0", mismatch_cnt); end
    q0.delete();
  endtask
  task automatic test_single();
    repeat (40) if (ecnt < 10) step();
    a[2] = 8'd5;
    b[2] = 8'd3;
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %0d exp 0", evt_valid); end
    step();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d exp 1", evt_valid); end
    checks++; if ({evt_ch, evt_eq, evt_a, evt_b, evt_time} !== {2'd2, 1'b0, 8'd5, 8'd3, 16'd10}) begin errors++; $display("FAIL single_fields: got ch=%0d eq=%0d a=%0d b=%0d t=%0d exp ch=2 eq=0 a=5 b=3 t=10", evt_ch, evt_eq, evt_a, evt_b, evt_time); end
    repeat (4) step();
    checks++; if (q0.size() != 1) begin errors++; $display("FAIL single_count: got %0d exp 1", q0.size()); end
    checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL single_mismatch: got %0d exp 1", mismatch_cnt); end
    q0.delete();
  endtask
  task automatic test_pair();
    t = ecnt;
    a[0] = 8'd7;
    b[3] = 8'd9;
    step();
    repeat (6) step();
    checks++; if (q0.size() != 2) begin errors++; $display("FAIL pair_count: got %0d exp 2", q0.size()); end
    if (q0.size() == 2) begin
      checks++; if (q0[0].ch != 0 || q0[1].ch != 3) begin errors++; $display("FAIL pair_order: got %0d,%0d exp 0,3", q0[0].ch, q0[1].ch); end
      checks++; if (q0[0].ts != t || q0[1].ts != t) begin errors++; $display("FAIL pair_time: got %0d,%0d exp %0d", q0[0].ts, q0[1].ts, t); end
    end
    checks++; if (mismatch_cnt !== 16'd3) begin errors++; $display("FAIL pair_mismatch: got %0d exp 3", mismatch_cnt); end
    q0.delete();
  endtask
  task automatic test_overflow();
    evt_ready = 1'b0;
    step();
    t = ecnt;
    for (int i = 1; i <= 12; i++) begin
      a[1] = 8'(i);
      step();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d exp 1", overflow); end
    checks++; if (evt_valid !== 1'b1 || evt_a !== 8'd1) begin errors++; $display("FAIL ovf_hold: got v=%0d a=%0d exp v=1 a=1", evt_valid, evt_a); end
    step();
    evt_ready = 1'b1;
    repeat (30) if (q0.size() < 9) step();
    repeat (3) step();
    checks++; if (q0.size() != 9) begin errors++; $display("FAIL ovf_count: got %0d exp 9", q0.size()); end
    for (int i = 0; i < 8 && i < q0.size(); i++) begin
      checks++; if (q0[i].ch != 1 || q0[i].a != i + 1 || q0[i].ts != t + i) begin errors++; $display("FAIL ovf_evt%0d: got ch=%0d a=%0d t=%0d exp ch=1 a=%0d t=%0d", i, q0[i].ch, q0[i].a, q0[i].ts, i + 1, t + i); end
    end
    if (q0.size() == 9) begin
      checks++; if (q0[8].a != 12 || q0[8].ts != t + 11) begin errors++; $display("FAIL ovf_last: got a=%0d t=%0d exp a=12 t=%0d", q0[8].a, q0[8].ts, t + 11); end
    end
    checks++; if (mismatch_cnt !== 16'd12) begin errors++; $display("FAIL ovf_mismatch: got %0d exp 12", mismatch_cnt); end
    q0.delete();
  endtask
  task automatic test_clr();
    a[0] = 8'd20;
    step();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL clr_push: got %0d exp 1", evt_valid); end
    checks++; if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d/%0d exp 0/0", match_cnt, mismatch_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0d exp 0", overflow); end
    repeat (3) step();
    checks++; if (q0.size() != 1 || (q0.size() == 1 && q0[0].a != 20)) begin errors++; $display("FAIL clr_evt: got n=%0d exp n=1 a=20", q0.size()); end
    q0.delete();
  endtask
  task automatic test_reset_mid();
    evt_ready = 1'b0;
    a[2] = 8'd44;
    step();
    step();
    checks++; if (evt_valid !== 1'b1 || mismatch_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre: got v=%0d mm=%0d exp v=1 mm=1", evt_valid, mismatch_cnt); end
    rst = 1'b1;
    en = 1'b0;
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0d exp 0", evt_valid); end
    checks++; if (mismatch_cnt !== 16'd0 || match_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt: got %0d/%0d exp 0/0", match_cnt, mismatch_cnt); end
    rst = 1'b0;
    en = 1'b1;
    evt_ready = 1'b1;
    q0.delete();
    step();
    repeat (20) if (q0.size() < 4) step();
    checks++; if (q0.size() != 4) begin errors++; $display("FAIL rmid_count: got %0d exp 4", q0.size()); end
    for (int k = 0; k < 4 && k < q0.size(); k++) begin
      checks++; if (q0[k].ch != k || q0[k].ts != 0) begin errors++; $display("FAIL rmid_evt%0d: got ch=%0d t=%0d exp ch=%0d t=0", k, q0[k].ch, q0[k].ts, k); end
    end
    if (q0.size() == 4) begin
      checks++; if (q0[2].a != 44) begin errors++; $display("FAIL rmid_val: got %0d exp 44", q0[2].a); end
    end
  endtask
  task automatic test_wrap();
    rst1 = 1'b0;
    en1 = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      if (e == 15) a1[0] = 8'd1;
      if (e == 16) a1[0] = 8'd2;
      step();
    end
    en1 = 1'b0;
    repeat (6) step();
    checks++; if (q1.size() != 6) begin errors++; $display("FAIL wrap_count: got %0d exp 6", q1.size()); end
    if (q1.size() == 6) begin
      checks++; if (q1[4].a != 1 || q1[4].ts != 15) begin errors++; $display("FAIL wrap_pre: got a=%0d t=%0d exp a=1 t=15", q1[4].a, q1[4].ts); end
      checks++; if (q1[5].a != 2 || q1[5].ts != 0) begin errors++; $display("FAIL wrap_post: got a=%0d t=%0d exp a=2 t=0", q1[5].a, q1[5].ts); end
    end
  endtask
  initial begin
    test_reset();
    test_prime();
    test_single();
    test_pair();
    test_overflow();
    test_clr();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_event_monitor.md
Name: cmp_event_monitor

Overview:
- Synthesisable, parametrised successor to the team's display/compare monitors.
- Each enabled cycle it samples NCH channel pairs (a, b). Any change on a channel produces a timestamped event record carrying the a==b verdict (TRUE/FALSE).
- Events are buffered in a FIFO and drained over a valid/ready port. Match/mismatch statistics and a lost-event flag are kept.
- Sits beside DUT buses in benches and on-chip debug paths, replacing $monitor/$display-style observation.

Parameters:
- NCH, 4, number of monitored channels (1..16)
- W, 8, width of each a/b value
- DEPTH, 8, event FIFO depth (power of 2, >=2)
- TSW, 16, timestamp width
- CW, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  sample enable; timestamp advances only when high
- a_i  in  NCH*W  channel a values; channel k at [k*W +: W]
- b_i  in  NCH*W  channel b values, same packing
- clr_stats  in  1  clears counters and overflow
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_ch  out  max(1,$clog2(NCH))  channel index
- evt_eq  out  1  a==b at capture
- evt_a  out  W  captured a
- evt_b  out  W  captured b
- evt_time  out  TSW  timestamp at capture
- match_cnt  out  CW  events pushed with eq=1
- mismatch_cnt  out  CW  events pushed with eq=0
- overflow  out  1  sticky: an event was coalesced (lost)

Behaviour:
- Reset: all outputs 0; FIFO empty; pending[] = 0; primed[] = 0; timestamp = 0; last-value registers = 0.
- Reset mid-operation discards FIFO contents and pending snapshots. evt_valid = 0 on the cycle after the rst edge.
- Timestamp: increments by 1 on each en=1 edge and wraps 2^TSW-1 -> 0. Holds when en=0.
- Change detect, at an edge with en=1, per channel k: change = !primed[k] | (a!=last_a[k]) | (b!=last_b[k]).
  - On change: snapshot {a, b, a==b, current timestamp} into channel k's slot; set pending[k] and primed[k].
  - last_a/last_b update every en=1 edge.
- Coalescing: if pending[k] is already set and channel k changes again, the snapshot is overwritten with the newest values and overflow is set.
  - This also applies when k is being pushed on the same edge: the push wins and the new change re-sets pending[k]. In that case overflow is not set.
- Arbitration: fixed priority, lowest pending index first. At most one push per cycle, and only when the FIFO is not full.
  - The pushed channel's pending bit clears.
  - Arbitration and draining continue while en=0.
- Latency: input change at edge n -> pending at n -> pushed at n+1 -> evt_valid=1 after n+1 (2 cycles, uncontended).
- FIFO: registered, first-word-fall-through.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are legal when full.
  - Output fields hold stable while evt_valid=1 and evt_ready=0.
- Counters: on each push, match_cnt+1 if eq, else mismatch_cnt+1. Counters saturate at 2^CW-1.
- clr_stats: counters -> 0 and overflow -> 0 on that edge. clr_stats wins over a simultaneous increment or overflow set. FIFO and pending are unaffected.

Decomposition:
- Package cmp_mon_pkg holds:
  - the event record typedef (ch, eq, a, b, time), parametrised via localparam widths derived from defaults;
  - a function for channel-index width.
- Sub-module sync_fifo (DEPTH, width = event record width): first-word-fall-through, full/empty outputs.
- Change detect, snapshot slots, arbiter and counters stay in the top.

Test Plan:
- Reset, then en=1 with all a=b=0 (NCH=4) -> events ch0,1,2,3 in order; each eq=1, time=0; match_cnt=4, mismatch_cnt=0.
- Hold steady, then set ch2 a=5, b=3 at timestamp 10 -> exactly one event: ch=2, eq=0, a=5, b=3, time=10; mismatch_cnt+1; evt_valid two cycles after the change.
- Set ch0 and ch3 in the same cycle -> ch0 event then ch3 event, identical evt_time.
- evt_ready=0; change ch1 on 12 consecutive cycles with DEPTH=8 -> FIFO holds 8 events, overflow=1, and the pending ch1 snapshot carries the 12th value. Release evt_ready -> 9 events drained, in order.
- Assert clr_stats on the same edge as a push -> match_cnt=mismatch_cnt=0 and overflow=0 afterwards. With TSW=4, run 17 enabled cycles -> timestamp wraps 15->0.
- Assert rst with FIFO non-empty -> evt_valid=0 next cycle and counters 0. The next en=1 re-primes and emits NCH events at time 0.
